beta_read_seq: RTL
==================

BETA_READ_SEQ -- requirements
Module: beta_read_seq

Interface
REQ-001 Parameter Q, 6: bits per beta value.
REQ-002 Parameter P, 128: beta values per read beat.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  layer read request valid.
REQ-006 req_layer  input  5  layer to read, legal 1..8.
REQ-007 req_ready  output  1  sequencer accepts a request.
REQ-008 req_err  output  1  one-cycle pulse when an illegal layer is accepted.
REQ-009 r_en  output  1  read enable to the beta store.
REQ-010 layer_r  output  5  layer presented to the beta store.
REQ-011 cntb  output  4  beat index presented to the beta store.
REQ-012 b_rd  input  P*Q  beta store read data, valid exactly 1 cycle after r_en.
REQ-013 dout  output  P*Q  beat data to the consumer.
REQ-014 dout_valid  output  1  dout holds a valid beat.
REQ-015 dout_ready  input  1  consumer accepts the beat.
REQ-016 dout_last  output  1  beat is the final beat of its layer.
REQ-017 dout_beat  output  4  beat index of the presented beat.

Function
REQ-018 FSM states IDLE, READ, DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: req_valid with layer 1..8 latches the layer, clears the issue count, and moves to READ; layer 0 or 9..31 pulses req_err for 1 cycle and stays in IDLE.
REQ-020 Beats per layer: 2 for layer 8 (cntb 0 then 1); 1 for layers 1..7 (cntb 0).
REQ-021 READ: r_en=1 in a cycle only if FIFO occupancy plus in-flight count < 2; layer_r=latched layer and cntb=issue count in that cycle.
REQ-022 layer_r and cntb SHALL be 0 whenever r_en=0.
REQ-023 Read latency: b_rd is captured into a 2-entry FIFO in the cycle after r_en=1, with its beat index and a last flag; capture is unconditional because a credit was reserved.
REQ-024 READ -> DRAIN in the cycle the last beat is issued; DRAIN -> IDLE when the FIFO is empty, nothing is in flight, and no capture is pending.
REQ-025 dout, dout_beat, and dout_last SHALL come from the FIFO head; dout_valid = FIFO not empty; a beat is popped on dout_valid && dout_ready.
REQ-026 A simultaneous capture and pop in one cycle SHALL keep occupancy unchanged and preserve order.
REQ-027 dout and its sidecars SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-028 The first dout_valid SHALL occur no earlier than 2 cycles after request acceptance; back-to-back beats reach 1 beat/cycle when dout_ready is held at 1.
REQ-029 A new request SHALL NOT be accepted until the previous layer fully drains.

Reset
REQ-030 rst SHALL force the FSM to IDLE, empty the FIFO, clear the in-flight and issue counters, and drive r_en, req_err, and dout_valid to 0; dout, dout_beat, dout_last, layer_r, and cntb SHALL be 0.
REQ-031 rst asserted during READ or DRAIN SHALL discard in-flight and buffered beats; no dout_valid is produced for them after reset.

Configuration
REQ-032 Macro BRD_MASK_EN: when defined, captured data bits at and above 2^L*Q SHALL be forced to 0 for layer L in 1..6; when undefined, b_rd is stored unmodified.

Verification
REQ-033 Layer 8 request, dout_ready=1 -> r_en with cntb 0,1 on consecutive cycles; two beats with dout_beat 0,1; dout_last only on beat 1; req_ready=1 again after drain.
REQ-034 Layer 3 request, dout_ready=1 -> one r_en with cntb=0; one beat with dout_last=1 and dout equal to b_rd of the following cycle.
REQ-035 Layer 8 request with dout_ready=0 for 10 cycles -> exactly 2 r_en pulses, dout stable at beat 0, no third issue; releasing dout_ready delivers beats 0 then 1 in order.
REQ-036 req_layer=0 and then 12 -> req_err pulses 1 cycle each, r_en stays 0, FSM stays IDLE.
REQ-037 rst asserted in the cycle after the first r_en of layer 8 -> dout_valid=0 and r_en=0 next cycle, req_ready=1, no stale beat appears afterwards.
REQ-038 BRD_MASK_EN defined, layer 2, b_rd all ones -> dout[4*Q-1:0] all ones and upper bits 0; undefined -> dout all ones.

Source files
------------

// File: rtl/beta_read_seq.sv
// Beta-store read sequencer: issues 1-2 credit-limited beat reads per layer and buffers them in a 2-entry FIFO.
// Optional BRD_MASK_EN zeroes captured bits at and above (2^L)*Q for layers 1..6.
module beta_read_seq #(
    parameter int Q = 6,
    parameter int P = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic [4:0]     req_layer,
    output logic           req_ready,
    output logic           req_err,
    output logic           r_en,
    output logic [4:0]     layer_r,
    output logic [3:0]     cntb,
    input  logic [P*Q-1:0] b_rd,
    output logic [P*Q-1:0] dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_last,
    output logic [3:0]     dout_beat,
    output logic [1:0]     state_dbg
);
    localparam int W = P * Q;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
    state_t state;

    logic [4:0]   layer_q;
    logic [1:0]   issue_cnt;
    logic         cap_pend;
    logic [3:0]   cap_beat;
    logic         cap_last;
    logic [W-1:0] data_mem [2];
    logic [3:0]   beat_mem [2];
    logic         last_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   last_idx;
    logic         issue_last;
    logic         pop;
    logic         layer_ok;
    logic [W-1:0] cap_data;

    // Handshakes: a request transfers on req_valid && req_ready; a beat transfers on dout_valid && dout_ready.
    assign req_ready  = (state == IDLE);
    assign layer_ok   = (req_layer >= 5'd1) && (req_layer <= 5'd8);
    assign last_idx   = (layer_q == 5'd8) ? 2'd1 : 2'd0;
    // The in-flight read (cap_pend) holds a reserved FIFO slot until it is captured.
    assign r_en       = (state == READ) && ((count + {1'b0, cap_pend}) < 2'd2);
    assign issue_last = r_en && (issue_cnt == last_idx);
    assign layer_r    = r_en ? layer_q : 5'd0;
    assign cntb       = r_en ? {2'b00, issue_cnt} : 4'd0;
    assign dout_valid = (count != 2'd0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = data_mem[rd_ptr];
    assign dout_beat  = beat_mem[rd_ptr];
    assign dout_last  = last_mem[rd_ptr];
    assign state_dbg  = state;

`ifdef BRD_MASK_EN
    always_comb begin
        cap_data = b_rd;
        if (layer_q >= 5'd1 && layer_q <= 5'd6)
            cap_data = b_rd & ~({W{1'b1}} << ((32'd1 << layer_q) * Q));
    end
`else
    assign cap_data = b_rd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            layer_q     <= 5'd0;
            issue_cnt   <= 2'd0;
            cap_pend    <= 1'b0;
            cap_beat    <= 4'd0;
            cap_last    <= 1'b0;
            req_err     <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            data_mem[0] <= '0;
            data_mem[1] <= '0;
            beat_mem[0] <= 4'd0;
            beat_mem[1] <= 4'd0;
            last_mem[0] <= 1'b0;
            last_mem[1] <= 1'b0;
        end else begin
            req_err  <= 1'b0;
            cap_pend <= r_en;
            cap_beat <= {2'b00, issue_cnt};
            cap_last <= issue_last;
            if (r_en)
                issue_cnt <= issue_cnt + 2'd1;
            if (cap_pend) begin
                data_mem[wr_ptr] <= cap_data;
                beat_mem[wr_ptr] <= cap_beat;
                last_mem[wr_ptr] <= cap_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({cap_pend, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (layer_ok) begin
                            layer_q   <= req_layer;
                            issue_cnt <= 2'd0;
                            state     <= READ;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (count == 2'd0 && !cap_pend)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
